// File: rtl/mram_host_pkg.sv
// Shared types and widths for the MRAM host request sequencer.
package mram_host_pkg;

    localparam int MRAM_AW    = 17;
    localparam int MRAM_DW    = 32;
    localparam int MRAM_LANES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STB     = 3'd1,
        RD_WAIT = 3'd2,
        RD_CAP  = 3'd3,
        WR_WAIT = 3'd4
    } state_e;

    // Reads always fetch the whole word; writes honour the host byte enables.
    function automatic logic [MRAM_LANES-1:0] strobe_ben(input logic                  is_write,
                                                         input logic [MRAM_LANES-1:0] req_ben);
        return is_write ? req_ben : {MRAM_LANES{1'b1}};
    endfunction

endpackage

// File: rtl/mram_err_log.sv
// Pair of saturating ECC event counters (corrected, uncorrectable) with a synchronous clear.
module mram_err_log #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_ce,
    input  logic             inc_ue,
    output logic [CNT_W-1:0] ce_cnt,
    output logic [CNT_W-1:0] ue_cnt
);

    logic [1:0]            inc;
    logic [1:0][CNT_W-1:0] cnt_all;

    assign inc = {inc_ue, inc_ce};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // Clear has priority over an increment landing in the same cycle.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign ce_cnt = cnt_all[0];
    assign ue_cnt = cnt_all[1];

endmodule

// File: rtl/mram_host_seq.sv
// Host request sequencer for the MRAM functional port: one access in flight, one-cycle response.
// Define MRAM_ERR_LOG_EN to add the ECC error counters (ERR_CE_CNT/ERR_UE_CNT/ERR_CLR).
module mram_host_seq
    import mram_host_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WR_TMO = 1023
`ifdef MRAM_ERR_LOG_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RSTb,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [MRAM_AW-1:0]    REQ_ADDR,
    input  logic [1:0]            REQ_NVR,
    input  logic [MRAM_LANES-1:0] REQ_BEN,
    input  logic [MRAM_DW-1:0]    REQ_WDATA,
    input  logic                  ECC_BYP,
    output logic                  RSP_VALID,
    output logic [MRAM_DW-1:0]    RSP_RDATA,
    output logic [MRAM_LANES-1:0] RSP_UE,
    output logic [MRAM_LANES-1:0] RSP_ERRF,
    output logic                  RSP_TMO,
    output logic [MRAM_AW-1:0]    A,
    output logic [1:0]            NVR,
    output logic [MRAM_LANES-1:0] BEN,
    output logic [MRAM_DW-1:0]    DIN,
    output logic                  CEb,
    output logic                  WEb,
    output logic                  ECCBYPS,
    input  logic [MRAM_DW-1:0]    DOUT,
    input  logic [MRAM_LANES-1:0] UE,
    input  logic [MRAM_LANES-1:0] ERRF,
`ifdef MRAM_ERR_LOG_EN
    input  logic                  ERR_CLR,
    output logic [CNT_W-1:0]      ERR_CE_CNT,
    output logic [CNT_W-1:0]      ERR_UE_CNT,
`endif
    input  logic                  WRC
);

    // One counter serves both the read-latency wait and the write timeout.
    localparam int             TMO_W   = $clog2(WR_TMO + 1);
    localparam int             TW      = (TMO_W > 4) ? TMO_W : 4;
    localparam logic [TW-1:0]  RD_LAST = TW'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [TW-1:0]  WR_LAST = TW'(WR_TMO - 1);

    state_e                state_q,     state_d;
    logic [TW-1:0]         cnt_q,       cnt_d;
    logic                  wr_q,        wr_d;
    logic                  ready_q,     ready_d;
    logic [MRAM_AW-1:0]    a_q,         a_d;
    logic [1:0]            nvr_q,       nvr_d;
    logic [MRAM_LANES-1:0] ben_q,       ben_d;
    logic [MRAM_DW-1:0]    din_q,       din_d;
    logic                  ceb_q,       ceb_d;
    logic                  web_q,       web_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [MRAM_DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [MRAM_LANES-1:0] rsp_ue_q,    rsp_ue_d;
    logic [MRAM_LANES-1:0] rsp_errf_q,  rsp_errf_d;
    logic                  rsp_tmo_q,   rsp_tmo_d;
    logic                  accept;

    assign accept = REQ_VALID & ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        a_d         = a_q;
        nvr_d       = nvr_q;
        ben_d       = ben_q;
        din_d       = din_q;
        ceb_d       = 1'b1;
        web_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_ue_d    = rsp_ue_q;
        rsp_errf_d  = rsp_errf_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = REQ_ADDR;
                    nvr_d   = REQ_NVR;
                    ben_d   = strobe_ben(REQ_WRITE, REQ_BEN);
                    din_d   = REQ_WDATA;
                    wr_d    = REQ_WRITE;
                    ceb_d   = 1'b0;
                    web_d   = ~REQ_WRITE;
                    cnt_d   = '0;
                    state_d = STB;
                end
            end
            STB: begin
                cnt_d = '0;
                if (wr_q) begin
                    state_d = WR_WAIT;
                end else if (RD_LAT == 1) begin
                    state_d = RD_CAP;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    state_d = RD_CAP;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            RD_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = DOUT;
                rsp_ue_d    = UE;
                rsp_errf_d  = ERRF;
                rsp_tmo_d   = 1'b0;
                state_d     = IDLE;
            end
            WR_WAIT: begin
                // WRC may not have risen yet in the cycle right after the strobe.
                if ((cnt_q != '0) && !WRC) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_ue_d    = '0;
                    rsp_errf_d  = '0;
                    rsp_tmo_d   = 1'b0;
                    state_d     = IDLE;
                end else if (cnt_q == WR_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_ue_d    = '0;
                    rsp_errf_d  = '0;
                    rsp_tmo_d   = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is withheld during the response cycle and reopens the cycle after.
        ready_d = (state_d == IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            ready_q     <= 1'b1;
            a_q         <= '0;
            nvr_q       <= '0;
            ben_q       <= '0;
            din_q       <= '0;
            ceb_q       <= 1'b1;
            web_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_ue_q    <= '0;
            rsp_errf_q  <= '0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            ready_q     <= ready_d;
            a_q         <= a_d;
            nvr_q       <= nvr_d;
            ben_q       <= ben_d;
            din_q       <= din_d;
            ceb_q       <= ceb_d;
            web_q       <= web_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_ue_q    <= rsp_ue_d;
            rsp_errf_q  <= rsp_errf_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign REQ_READY = ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_UE    = rsp_ue_q;
    assign RSP_ERRF  = rsp_errf_q;
    assign RSP_TMO   = rsp_tmo_q;
    assign A         = a_q;
    assign NVR       = nvr_q;
    assign BEN       = ben_q;
    assign DIN       = din_q;
    assign CEb       = ceb_q;
    assign WEb       = web_q;
    assign ECCBYPS   = ECC_BYP;

`ifdef MRAM_ERR_LOG_EN
    logic cap_ce;
    logic cap_ue;

    // A lane with an uncorrectable error outranks any corrected flag in the same word.
    assign cap_ue = (state_q == RD_CAP) && (|UE);
    assign cap_ce = (state_q == RD_CAP) && (|ERRF) && !(|UE);

    mram_err_log #(
        .CNT_W (CNT_W)
    ) u_err_log (
        .clk    (CLK),
        .rst_n  (RSTb),
        .clr    (ERR_CLR),
        .inc_ce (cap_ce),
        .inc_ue (cap_ue),
        .ce_cnt (ERR_CE_CNT),
        .ue_cnt (ERR_UE_CNT)
    );
`endif

endmodule

// File: tb/tb_mram_host_seq.sv
// Directed bench for mram_host_seq with a small behavioural MRAM macro model (RD_LAT=2, WR_TMO=16).
module tb_mram_host_seq;

    localparam int RD_LAT = 2;
    localparam int WR_TMO = 16;

    logic        CLK;
    logic        RSTb;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WRITE;
    logic [16:0] REQ_ADDR;
    logic [1:0]  REQ_NVR;
    logic [3:0]  REQ_BEN;
    logic [31:0] REQ_WDATA;
    logic        ECC_BYP;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic [3:0]  RSP_UE;
    logic [3:0]  RSP_ERRF;
    logic        RSP_TMO;
    logic [16:0] A;
    logic [1:0]  NVR;
    logic [3:0]  BEN;
    logic [31:0] DIN;
    logic        CEb;
    logic        WEb;
    logic        ECCBYPS;
    logic [31:0] DOUT;
    logic [3:0]  UE;
    logic [3:0]  ERRF;
    logic        WRC;
`ifdef MRAM_ERR_LOG_EN
    logic        ERR_CLR;
    logic [15:0] ERR_CE_CNT;
    logic [15:0] ERR_UE_CNT;
`endif

    int checks = 0;
    int errors = 0;

    mram_host_seq #(
        .RD_LAT (RD_LAT),
        .WR_TMO (WR_TMO)
    ) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_NVR   (REQ_NVR),
        .REQ_BEN   (REQ_BEN),
        .REQ_WDATA (REQ_WDATA),
        .ECC_BYP   (ECC_BYP),
        .RSP_VALID (RSP_VALID),
        .RSP_RDATA (RSP_RDATA),
        .RSP_UE    (RSP_UE),
        .RSP_ERRF  (RSP_ERRF),
        .RSP_TMO   (RSP_TMO),
        .A         (A),
        .NVR       (NVR),
        .BEN       (BEN),
        .DIN       (DIN),
        .CEb       (CEb),
        .WEb       (WEb),
        .ECCBYPS   (ECCBYPS),
        .DOUT      (DOUT),
        .UE        (UE),
        .ERRF      (ERRF),
`ifdef MRAM_ERR_LOG_EN
        .ERR_CLR    (ERR_CLR),
        .ERR_CE_CNT (ERR_CE_CNT),
        .ERR_UE_CNT (ERR_UE_CNT),
`endif
        .WRC       (WRC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Macro model: read data is valid only in the cycle RD_LAT after the strobe cycle.
    logic        use_fixed  = 1'b0;
    logic [31:0] fixed_word = 32'h0;
    logic [3:0]  model_ue   = 4'h0;
    logic [3:0]  model_errf = 4'h0;
    logic [31:0] pend_data  = 32'h0;
    int          lat_cnt    = 0;
    int          wrc_cnt    = 0;
    int          wrc_len    = 5;
    logic        wrc_stuck  = 1'b0;

    function automatic logic [31:0] addr_word(input logic [16:0] addr);
        return 32'hC0DE_0000 ^ {15'h0, addr};
    endfunction

    always @(posedge CLK) begin
        if (!CEb && WEb) begin
            lat_cnt   <= RD_LAT - 1;
            pend_data <= use_fixed ? fixed_word : addr_word(A);
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
        end
        DOUT <= (lat_cnt == 1) ? pend_data  : 32'h0BAD_F00D;
        UE   <= (lat_cnt == 1) ? model_ue   : 4'hF;
        ERRF <= (lat_cnt == 1) ? model_errf : 4'hF;
        if (!CEb && !WEb) begin
            wrc_cnt <= wrc_len;
        end else if (wrc_cnt != 0) begin
            wrc_cnt <= wrc_cnt - 1;
        end
    end

    assign WRC = wrc_stuck || (wrc_cnt != 0);

    // Presents a request at a negedge and returns at the negedge just before the accepting edge.
    task automatic start_req(input logic wr, input logic [16:0] addr, input logic [1:0] nvr,
                             input logic [3:0] ben, input logic [31:0] wd, output bit ok);
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_NVR   = nvr;
        REQ_BEN   = ben;
        REQ_WDATA = wd;
        REQ_VALID = 1'b1;
        for (int k = 0; k < 50 && !REQ_READY; k++) @(negedge CLK);
        ok = REQ_READY;
    endtask

    task automatic test_reset();
        RSTb = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_NVR = '0;
        REQ_BEN = '0; REQ_WDATA = '0; ECC_BYP = 1'b0;
`ifdef MRAM_ERR_LOG_EN
        ERR_CLR = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);
        checks++; if ({CEb, WEb} !== 2'b11) begin errors++; $display("FAIL reset_ceb_web got %b want 11", {CEb, WEb}); end
        checks++; if ({A, NVR, BEN, DIN} !== 55'h0) begin errors++; $display("FAIL reset_macro_bus got %h want 0", {A, NVR, BEN, DIN}); end
        checks++; if ({RSP_VALID, RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO} !== 42'h0) begin errors++; $display("FAIL reset_rsp got %h want 0", {RSP_VALID, RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO}); end
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", REQ_READY); end
        ECC_BYP = 1'b1; #1;
        checks++; if (ECCBYPS !== 1'b1) begin errors++; $display("FAIL eccbyps got %b want 1", ECCBYPS); end
        ECC_BYP = 1'b0;
`ifdef MRAM_ERR_LOG_EN
        checks++; if ({ERR_CE_CNT, ERR_UE_CNT} !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", {ERR_CE_CNT, ERR_UE_CNT}); end
`endif
    endtask

    task automatic test_read();
        bit ok; int rsp_at = -1; int ceb_lows = 0;
        use_fixed = 1'b1; fixed_word = 32'hDEAD_BEEF; model_ue = 4'h0; model_errf = 4'h0;
        start_req(1'b0, 17'h00123, 2'd1, 4'h3, 32'h1234_5678, ok);
        checks++; if (!ok) begin errors++; $display("FAIL read_ready got 0 want 1"); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (!CEb) ceb_lows++;
            if (k == 1) begin
                checks++; if ({CEb, WEb, A, NVR, BEN} !== {2'b01, 17'h00123, 2'd1, 4'hF}) begin errors++; $display("FAIL read_strobe got %h want %h", {CEb, WEb, A, NVR, BEN}, {2'b01, 17'h00123, 2'd1, 4'hF}); end
                REQ_VALID = 1'b0; REQ_ADDR = 17'h0AAAA;
            end
            if (k == 3) begin
                checks++; if (A !== 17'h00123) begin errors++; $display("FAIL read_addr_hold got %h want 00123", A); end
            end
            if (RSP_VALID && rsp_at < 0) begin
                rsp_at = k;
                checks++; if ({RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO} !== {32'hDEAD_BEEF, 9'h0}) begin errors++; $display("FAIL read_rsp got %h want %h", {RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO}, {32'hDEAD_BEEF, 9'h0}); end
                checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL read_ready_in_rsp got %b want 0", REQ_READY); end
            end else if (rsp_at > 0 && k == rsp_at + 1) begin
                checks++; if ({REQ_READY, RSP_VALID, RSP_RDATA} !== {2'b10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL read_after_rsp got %h want %h", {REQ_READY, RSP_VALID, RSP_RDATA}, {2'b10, 32'hDEAD_BEEF}); end
            end
        end
        checks++; if (rsp_at != 4) begin errors++; $display("FAIL read_latency got %0d want 4", rsp_at); end
        checks++; if (ceb_lows != 1) begin errors++; $display("FAIL read_strobes got %0d want 1", ceb_lows); end
    endtask

    task automatic test_write();
        bit ok; int rsp_at = -1; int ceb_lows = 0; int web_lows = 0;
        wrc_len = 5;
        start_req(1'b1, 17'h1FFFF, 2'd2, 4'b0101, 32'hA5A5_A5A5, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_ready got 0 want 1"); end
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (!CEb) ceb_lows++;
            if (!WEb) web_lows++;
            if (k == 1) begin
                checks++; if ({CEb, WEb, A, NVR, BEN, DIN} !== {2'b00, 17'h1FFFF, 2'd2, 4'b0101, 32'hA5A5_A5A5}) begin errors++; $display("FAIL write_strobe got %h want %h", {CEb, WEb, A, NVR, BEN, DIN}, {2'b00, 17'h1FFFF, 2'd2, 4'b0101, 32'hA5A5_A5A5}); end
                REQ_VALID = 1'b0;
            end
            if (RSP_VALID && rsp_at < 0) begin
                rsp_at = k;
                checks++; if ({RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO} !== 41'h0) begin errors++; $display("FAIL write_rsp got %h want 0", {RSP_RDATA, RSP_UE, RSP_ERRF, RSP_TMO}); end
            end
        end
        checks++; if (rsp_at != 8) begin errors++; $display("FAIL write_latency got %0d want 8", rsp_at); end
        checks++; if (ceb_lows != 1 || web_lows != 1) begin errors++; $display("FAIL write_strobes got ceb %0d web %0d want 1 1", ceb_lows, web_lows); end
    endtask

    task automatic test_timeout();
        bit ok; int rsp_at = -1;
        wrc_stuck = 1'b1;
        start_req(1'b1, 17'h00042, 2'd0, 4'hF, 32'h0000_0001, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_ready got 0 want 1"); end
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            if (k == 1) REQ_VALID = 1'b0;
            if (k == 17) begin
                checks++; if ({REQ_READY, RSP_VALID} !== 2'b00) begin errors++; $display("FAIL tmo_busy got %b want 00", {REQ_READY, RSP_VALID}); end
            end
            if (RSP_VALID && rsp_at < 0) begin
                rsp_at = k;
                checks++; if ({RSP_TMO, REQ_READY} !== 2'b10) begin errors++; $display("FAIL tmo_rsp got %b want 10", {RSP_TMO, REQ_READY}); end
            end else if (rsp_at > 0 && k == rsp_at + 1) begin
                checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL tmo_ready_after got %b want 1", REQ_READY); end
            end
        end
        checks++; if (rsp_at != 18) begin errors++; $display("FAIL tmo_latency got %0d want 18", rsp_at); end
        wrc_stuck = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_ecc();
        bit ok; int rsp_at = -1;
        use_fixed = 1'b1; fixed_word = 32'h0102_0304; model_ue = 4'b0010; model_errf = 4'b0001;
        start_req(1'b0, 17'h00010, 2'd0, 4'h0, 32'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ecc_ready got 0 want 1"); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            if (k == 1) REQ_VALID = 1'b0;
            if (RSP_VALID && rsp_at < 0) begin
                rsp_at = k;
                checks++; if ({RSP_RDATA, RSP_UE, RSP_ERRF} !== {32'h0102_0304, 4'b0010, 4'b0001}) begin errors++; $display("FAIL ecc_rsp got %h want %h", {RSP_RDATA, RSP_UE, RSP_ERRF}, {32'h0102_0304, 4'b0010, 4'b0001}); end
            end
        end
        checks++; if (rsp_at != 4) begin errors++; $display("FAIL ecc_latency got %0d want 4", rsp_at); end
`ifdef MRAM_ERR_LOG_EN
        checks++; if ({ERR_UE_CNT, ERR_CE_CNT} !== {16'd1, 16'd0}) begin errors++; $display("FAIL ecc_cnt1 got ue %0d ce %0d want 1 0", ERR_UE_CNT, ERR_CE_CNT); end
        model_ue = 4'b0000; model_errf = 4'b1000;
        start_req(1'b0, 17'h00011, 2'd0, 4'h0, 32'h0, ok);
        repeat (6) begin @(negedge CLK); REQ_VALID = 1'b0; end
        checks++; if ({ERR_UE_CNT, ERR_CE_CNT} !== {16'd1, 16'd1}) begin errors++; $display("FAIL ecc_cnt2 got ue %0d ce %0d want 1 1", ERR_UE_CNT, ERR_CE_CNT); end
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        checks++; if ({ERR_UE_CNT, ERR_CE_CNT} !== 32'h0) begin errors++; $display("FAIL ecc_clr got ue %0d ce %0d want 0 0", ERR_UE_CNT, ERR_CE_CNT); end
`endif
        model_ue = 4'h0; model_errf = 4'h0;
    endtask

    task automatic test_back_to_back();
        int issued = 0; int rsps = 0; int strobes = 0; int overlaps = 0;
        bit pend = 0; bit prev_low = 0;
        logic [31:0] exp;
        use_fixed = 1'b0; wrc_len = 2;
        REQ_WRITE = 1'b0; REQ_ADDR = 17'h100; REQ_NVR = 2'd0; REQ_BEN = 4'hF; REQ_WDATA = 32'h1000_0000;
        REQ_VALID = 1'b1;
        for (int k = 0; k < 200 && rsps < 8; k++) begin
            if (pend) begin
                pend = 0;
                issued++;
                if (issued < 8) begin
                    REQ_WRITE = issued[0];
                    REQ_ADDR  = 17'h100 + 17'(issued * 3);
                    REQ_WDATA = 32'h1000_0000 + 32'(issued);
                end else begin
                    REQ_VALID = 1'b0;
                end
            end
            if (REQ_VALID && REQ_READY) pend = 1;
            if (!CEb) begin
                strobes++;
                if (prev_low) overlaps++;
            end
            prev_low = !CEb;
            if (RSP_VALID) begin
                exp = rsps[0] ? 32'h0 : addr_word(17'h100 + 17'(rsps * 3));
                checks++; if ({RSP_RDATA, RSP_TMO} !== {exp, 1'b0}) begin errors++; $display("FAIL b2b_rsp%0d got %h want %h", rsps, {RSP_RDATA, RSP_TMO}, {exp, 1'b0}); end
                rsps++;
            end
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        checks++; if (rsps != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", rsps); end
        checks++; if (strobes != 8 || overlaps != 0) begin errors++; $display("FAIL b2b_strobes got %0d overlap %0d want 8 0", strobes, overlaps); end
    endtask

    task automatic test_reset_mid();
        bit ok; int stray;
        for (int s = 0; s < 2; s++) begin
            stray = 0; wrc_len = 5;
            start_req(1'b1, 17'h00ABC, 2'd3, 4'hC, 32'h5555_AAAA, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rstmid%0d_ready got 0 want 1", s); end
            @(negedge CLK);
            REQ_VALID = 1'b0;
            if (s == 0) begin
                checks++; if ({CEb, WEb} !== 2'b00) begin errors++; $display("FAIL rstmid_in_stb got %b want 00", {CEb, WEb}); end
            end else begin
                repeat (2) @(negedge CLK);
            end
            #1 RSTb = 1'b0;
            #1;
            checks++; if ({CEb, WEb, RSP_VALID} !== 3'b110) begin errors++; $display("FAIL rstmid%0d_drop got %b want 110", s, {CEb, WEb, RSP_VALID}); end
            @(negedge CLK);
            RSTb = 1'b1;
            for (int k = 0; k < 25; k++) begin
                @(negedge CLK);
                if (RSP_VALID) stray++;
            end
            checks++; if (stray != 0 || REQ_READY !== 1'b1) begin errors++; $display("FAIL rstmid%0d_after got rsp %0d ready %b want 0 1", s, stray, REQ_READY); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ecc();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
